// File: rtl/ternary_serial_addsub_if.sv
// Handshake and operand/result bundle for the digit-serial ternary add/subtract unit.
// Trit i of every word occupies bits [2i+1:2i] (2'b00=0, 2'b01=1, 2'b10=2).
interface ternary_serial_addsub_if #(
    parameter int TRITS = 4
);
    logic                 start;
    logic                 op;
    logic                 cin;
    logic [2*TRITS-1:0]   a;
    logic [2*TRITS-1:0]   b;
    logic                 busy;
    logic                 done;
    logic [2*TRITS-1:0]   result;
    logic                 cout;
    logic                 err;

    // Requester side: issues operands and start, observes status/result
    modport master (
        output start, op, cin, a, b,
        input  busy, done, result, cout, err
    );

    // Arithmetic unit side
    modport slave (
        input  start, op, cin, a, b,
        output busy, done, result, cout, err
    );
endinterface

// File: rtl/ternary_serial_addsub.sv
// Digit-serial unbalanced-ternary add/subtract unit.
// One trit per clock, LSB first, through a single full add/subtract cell whose
// carry/borrow is held in a register between trits. Operands with an illegal
// 2'b11 trit are rejected immediately with err set.
module ternary_serial_addsub #(
    parameter int TRITS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    ternary_serial_addsub_if.slave bus
);

    localparam int W     = 2 * TRITS;
    localparam int IDX_W = (TRITS > 1) ? $clog2(TRITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic               op_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic [W-1:0]       result_q;
    logic               cout_q;
    logic               err_q;
    logic               busy_q;
    logic               done_q;

    logic [1:0]         x_d;
    logic [1:0]         y_d;
    logic [1:0]         digit_d;
    logic               carry_d;

    // True when any trit of the word carries the illegal code 2'b11
    function automatic logic has_illegal(input logic [W-1:0] w);
        for (int i = 0; i < TRITS; i++) begin
            if (w[2*i +: 2] == 2'b11) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Full add/subtract cell: returns {carry_out, digit}.
    // Subtraction is biased by +3 so the intermediate stays non-negative:
    // a biased value below 3 means the true difference was negative (borrow).
    function automatic logic [2:0] trit_cell(input logic op, input logic [1:0] x,
                                             input logic [1:0] y, input logic c);
        logic [2:0] t;
        if (op) begin
            t = {1'b0, x} + {1'b0, y} + {2'b00, c};
            if (t >= 3'd3) return {1'b1, 2'(t - 3'd3)};
            else           return {1'b0, t[1:0]};
        end else begin
            t = {1'b0, x} + 3'd3 - {1'b0, y} - {2'b00, c};
            if (t < 3'd3)  return {1'b1, t[1:0]};
            else           return {1'b0, 2'(t - 3'd3)};
        end
    endfunction

    // Select the current trit pair and evaluate the cell against the carry register
    always_comb begin
        x_d                = 2'(a_q >> (2 * idx_q));
        y_d                = 2'(b_q >> (2 * idx_q));
        {carry_d, digit_d} = trit_cell(op_q, x_d, y_d, carry_q);
    end

    // Control FSM with registered status outputs and result accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            err_q    <= 1'b0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        op_q     <= bus.op;
                        result_q <= '0;
                        cout_q   <= 1'b0;
                        err_q    <= 1'b0;
                        if (has_illegal(bus.a) || has_illegal(bus.b)) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            idx_q   <= '0;
                            carry_q <= bus.cin;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    // Unwritten trits are zero, so OR-ing the new digit in place is exact
                    result_q <= result_q | (W'(digit_d) << (2 * idx_q));
                    carry_q  <= carry_d;
                    idx_q    <= idx_q + 1'b1;
                    if (idx_q == IDX_W'(TRITS - 1)) begin
                        cout_q  <= carry_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_ternary_serial_addsub.sv
// Self-checking bench for ternary_serial_addsub (TRITS=4): directed scenarios
// plus randomized requests compared against an integer-arithmetic reference.
module tb_ternary_serial_addsub;

    localparam int T = 4;
    localparam int W = 2 * T;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    ternary_serial_addsub_if #(.TRITS(T)) ifc ();

    ternary_serial_addsub #(.TRITS(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decode words to integers, do plain arithmetic, re-encode
    function automatic void model(input logic op, input logic cin,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic co, output logic e);
        int va, vb, t, p, modv;
        logic [1:0] ta, tb;
        e = 1'b0; va = 0; vb = 0; p = 1;
        for (int i = 0; i < T; i++) begin
            ta = a[2*i +: 2];
            tb = b[2*i +: 2];
            if (ta == 2'b11 || tb == 2'b11) e = 1'b1;
            va += int'(ta) * p;
            vb += int'(tb) * p;
            p *= 3;
        end
        modv = p;
        r  = '0;
        co = 1'b0;
        if (e) return;
        if (op) begin
            t  = va + vb + int'(cin);
            co = (t >= modv);
            t  = t % modv;
        end else begin
            t  = va - vb - int'(cin);
            co = (t < 0);
            if (t < 0) t += modv;
        end
        for (int i = 0; i < T; i++) begin
            r[2*i +: 2] = 2'(t % 3);
            t = t / 3;
        end
    endfunction

    // Issue one request and check handshake timing, busy profile and results
    task automatic run_op(input logic op, input logic cin,
                          input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        logic [W-1:0] er;
        logic eco, ee;
        int n, exp_lat;
        bit seen;
        model(op, cin, a, b, er, eco, ee);
        exp_lat = ee ? 1 : T + 1;
        @(posedge clk); #1;
        ifc.op = op; ifc.cin = cin; ifc.a = a; ifc.b = b; ifc.start = 1'b1;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        seen = 0;
        n = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            checks++;
            if (ifc.busy !== (!ee && n <= T)) begin
                errors++;
                $display("FAIL %s busy cycle %0d: got %b want %b", tag, n, ifc.busy, (!ee && n <= T));
            end
            if (ifc.done === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || n != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d (done seen %0d) want %0d", tag, n, seen, exp_lat);
        end
        checks++;
        if (ifc.result !== er || ifc.cout !== eco || ifc.err !== ee) begin
            errors++;
            $display("FAIL %s result: got r=%h co=%b err=%b want r=%h co=%b err=%b",
                     tag, ifc.result, ifc.cout, ifc.err, er, eco, ee);
        end
        @(negedge clk);
        checks++;
        if (ifc.done !== 1'b0 || ifc.result !== er || ifc.cout !== eco || ifc.err !== ee) begin
            errors++;
            $display("FAIL %s hold: got done=%b r=%h co=%b err=%b want done=0 r=%h co=%b err=%b",
                     tag, ifc.done, ifc.result, ifc.cout, ifc.err, er, eco, ee);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ifc.busy, ifc.done, ifc.cout, ifc.err} !== 4'b0000 || ifc.result !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b r=%h co=%b err=%b want all 0",
                     ifc.busy, ifc.done, ifc.result, ifc.cout, ifc.err);
        end
        rst = 1'b0;
    endtask

    task automatic test_sub();
        run_op(1'b0, 1'b0, 8'h91, 8'h66, "sub_64_50");
        checks++;
        if (ifc.result !== 8'h16) begin
            errors++;
            $display("FAIL sub_64_50_const: got %h want 16", ifc.result);
        end
        run_op(1'b0, 1'b0, 8'h00, 8'h01, "sub_wrap_b");
        run_op(1'b0, 1'b1, 8'h00, 8'h00, "sub_wrap_cin");
        checks++;
        if (ifc.result !== 8'hAA || ifc.cout !== 1'b1) begin
            errors++;
            $display("FAIL sub_wrap_const: got r=%h co=%b want r=aa co=1", ifc.result, ifc.cout);
        end
    endtask

    task automatic test_add();
        run_op(1'b1, 1'b0, 8'hAA, 8'h01, "add_overflow");
        checks++;
        if (ifc.result !== 8'h00 || ifc.cout !== 1'b1) begin
            errors++;
            $display("FAIL add_overflow_const: got r=%h co=%b want r=00 co=1", ifc.result, ifc.cout);
        end
        run_op(1'b1, 1'b1, 8'h01, 8'h01, "add_cin");
        checks++;
        if (ifc.result !== 8'h04 || ifc.cout !== 1'b0) begin
            errors++;
            $display("FAIL add_cin_const: got r=%h co=%b want r=04 co=0", ifc.result, ifc.cout);
        end
    endtask

    task automatic test_illegal();
        run_op(1'b0, 1'b0, 8'h03, 8'h12, "illegal_a");
        run_op(1'b1, 1'b1, 8'h21, 8'hC0, "illegal_b");
        // A subsequent legal request must clear err
        run_op(1'b1, 1'b0, 8'h12, 8'h21, "after_illegal");
    endtask

    // Extra starts during RUN and DONE must be ignored
    task automatic test_ignore_start();
        int dones, n;
        @(negedge clk);
        ifc.op = 1'b0; ifc.cin = 1'b0; ifc.a = 8'h91; ifc.b = 8'h66; ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        dones = 0;
        n = 0;
        while (n < T + 6) begin
            n++;
            if (n == 2) begin
                ifc.op = 1'b1; ifc.cin = 1'b1; ifc.a = 8'h22; ifc.b = 8'h22; ifc.start = 1'b1;
            end else if (ifc.done !== 1'b1) begin
                ifc.start = 1'b0;
            end
            if (ifc.done === 1'b1) begin
                dones++;
                ifc.op = 1'b1; ifc.cin = 1'b0; ifc.a = 8'h01; ifc.b = 8'h01; ifc.start = 1'b1;
            end
            @(negedge clk);
        end
        ifc.start = 1'b0;
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL ignore_start_dones: got %0d want 1", dones);
        end
        checks++;
        if (ifc.result !== 8'h16 || ifc.cout !== 1'b0 || ifc.err !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_result: got r=%h co=%b err=%b want r=16 co=0 err=0",
                     ifc.result, ifc.cout, ifc.err);
        end
    endtask

    // Reset in the second RUN cycle aborts without done
    task automatic test_reset_mid_run();
        int dones;
        @(negedge clk);
        ifc.op = 1'b1; ifc.cin = 1'b0; ifc.a = 8'h2A; ifc.b = 8'h15; ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.result !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: got busy=%b done=%b r=%h want 0 0 00",
                     ifc.busy, ifc.done, ifc.result);
        end
        dones = 0;
        repeat (T + 3) begin
            @(negedge clk);
            if (ifc.done === 1'b1 || ifc.busy === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL reset_mid_run_quiet: got %0d active cycles want 0", dones);
        end
        run_op(1'b0, 1'b0, 8'h91, 8'h66, "after_reset");
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic op, cin;
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < T; i++) begin
                a[2*i +: 2] = 2'($urandom_range(0, 2));
                b[2*i +: 2] = 2'($urandom_range(0, 2));
            end
            if ($urandom_range(0, 9) == 0) a[2*$urandom_range(0, T-1) +: 2] = 2'b11;
            op  = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
            run_op(op, cin, a, b, $sformatf("random_%0d", k));
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        ifc.start = 1'b0; ifc.op = 1'b0; ifc.cin = 1'b0; ifc.a = '0; ifc.b = '0;
        test_reset();
        test_sub();
        test_add();
        test_illegal();
        test_ignore_start();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ternary_serial_addsub.md
Name: ternary_serial_addsub

Overview:
- Digit-serial, parametrised ternary add/subtract unit for TRITS-wide unbalanced-ternary words.
- Each trit is 2-bit encoded: 2'b00=0, 2'b01=1, 2'b10=2; 2'b11 is illegal.
- Processes one trit per clock, LSB first, through a single full add/subtract cell with a registered carry/borrow.
- Successor to the combinational single-trit full subtractor: adds word width, an add mode, carry-in chaining, illegal-code detection and a start/done handshake.

Parameters:
TRITS, 4, number of trits per operand (>=1); bus width is 2*TRITS bits, trit i occupies bits [2i+1:2i].

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when busy=0 and done=0
- op  input  1  0 = subtract (a - b - cin), 1 = add (a + b + cin); sampled with start
- cin  input  1  initial borrow (sub) or carry (add), value 0/1; sampled with start
- a  input  2*TRITS  minuend/augend; sampled with start
- b  input  2*TRITS  subtrahend/addend; sampled with start
- busy  output  1  high while in RUN
- done  output  1  one-cycle completion pulse
- result  output  2*TRITS  difference/sum, valid from done until the next accepted start
- cout  output  1  final borrow (sub) or carry (add)
- err  output  1  illegal trit code detected in the last accepted request

Behaviour:
Reset:
- rst high at a clock edge forces IDLE and clears busy, done, result, cout and err to 0.
- Reset mid-RUN aborts the operation; no done is produced.
- Reset has priority over start.

States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0.
  - start=1 captures a, b, op and cin into internal registers and clears err.
  - If any trit of a or b is 2'b11: set err=1, result=0, cout=0, go to DONE (done one cycle after acceptance).
  - Otherwise: trit index=0, carry register=cin, go to RUN.
- RUN: busy=1. Each cycle, trit i of the captured operands is combined with the carry register (see Arithmetic).
  - The digit is written into result trit i; the carry register is updated; the index increments.
  - After trit TRITS-1: cout = final carry register, go to DONE.
  - RUN lasts exactly TRITS cycles.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. start is ignored in DONE.

Start while busy or done is ignored. It is not queued and captured operands are unchanged.

Latency:
- Legal request: start sampled at edge k, busy high for cycles k+1..k+TRITS, done high in cycle k+TRITS+1.
- Illegal request: done high in cycle k+1.

Arithmetic per trit (x=a_i, y=b_i, c=carry register, all integers):
- Subtract: t = x - y - c, range -3..2. If t<0: digit=t+3, carry=1; else digit=t, carry=0.
- Add: t = x + y + c, range 0..5. If t>=3: digit=t-3, carry=1; else digit=t, carry=0.
- The digit is never encoded as 2'b11.

Result bits:
- During RUN, result trits not yet written read as 2'b00.
- result, cout and err hold after DONE until the next accepted start (trits clear at acceptance) or until reset.

Wrap-around:
- Subtract with a < b + cin gives result = 3^TRITS + (a - b - cin) and cout=1.
- Add overflow gives result = (a + b + cin) mod 3^TRITS and cout=1.

Test Plan:
1. TRITS=4, op=0, cin=0, a=8'h91 ("2101"=64), b=8'h66 ("1212"=50) -> done 5 cycles after start, result=8'h16 ("0112"=14), cout=0, err=0.
2. op=0, cin=0, a=8'h00, b=8'h01 -> result=8'hAA ("2222"=80), cout=1. Repeat with a=b=8'h00, cin=1 -> result=8'hAA, cout=1.
3. op=1, cin=0, a=8'hAA, b=8'h01 -> result=8'h00, cout=1. op=1, cin=1, a=8'h01, b=8'h01 -> result=8'h00 plus trit0=0, trit1=1, i.e. 8'h04 ("0010"=3), cout=0.
4. a=8'h03 (trit0 illegal), start -> done in the next cycle, err=1, result=8'h00, cout=0, busy never asserted.
5. Start accepted, second start with different operands pulsed during RUN and during DONE -> ignored, result matches the first operands only, single done pulse.
6. rst asserted in the 2nd RUN cycle -> next cycle busy=0, result=0, no done. A fresh start afterwards completes normally with the scenario-1 values.
